// File: rtl/dpram_port_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single memory slave port.
// One command issues per cycle, granted round-robin. Outstanding reads are
// tagged with the issuing master in an in-order FIFO, so each returning read
// is steered back to the master that issued it.
module dpram_port_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_PEND = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic              m0_read,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic              m1_read,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic              s_read,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_readdatavalid,
  output logic              err_spurious
);

  localparam int unsigned     PtrW    = $clog2(MAX_PEND);
  localparam int unsigned     CntW    = $clog2(MAX_PEND + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(MAX_PEND);

  logic [MAX_PEND-1:0] tag_q;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     pend_cnt_q, pend_cnt_d;
  logic                last_grant_q, last_grant_d;
  logic [DATA_W-1:0]   m0_rdata_q, m1_rdata_q;
  logic                m0_rvalid_q, m1_rvalid_q;
  logic                err_q;

  logic pop, spurious, read_ok, elig0, elig1, issue, gnt, push, pop_tag;

  // Qualify requests, pick a winner and drive the slave command combinationally.
  always_comb begin
    pop      = s_readdatavalid && (pend_cnt_q != '0);
    spurious = s_readdatavalid && (pend_cnt_q == '0);
    // A full FIFO can still take a read if an entry frees up this same cycle.
    read_ok  = (pend_cnt_q != FullCnt) || pop;
    elig0    = m0_write || (m0_read && read_ok);
    elig1    = m1_write || (m1_read && read_ok);
    // Gated so nothing issues while reset is asserted.
    issue    = reset_n && (elig0 || elig1);
    gnt      = (elig0 && elig1) ? ~last_grant_q : elig1;

    s_address   = '0;
    s_writedata = '0;
    s_write     = 1'b0;
    s_read      = 1'b0;
    if (issue) begin
      s_address   = gnt ? m1_address   : m0_address;
      s_writedata = gnt ? m1_writedata : m0_writedata;
      s_write     = gnt ? m1_write     : m0_write;
      // Write wins when a master raises both strobes.
      s_read      = gnt ? (m1_read && !m1_write) : (m0_read && !m0_write);
    end
    push = s_read;

    m0_waitrequest = !(issue && !gnt);
    m1_waitrequest = !(issue && gnt);
  end

  // Next-state for tag pointers, outstanding count and round-robin pointer.
  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    pend_cnt_d   = pend_cnt_q + CntW'(push) - CntW'(pop);
    last_grant_d = issue ? gnt : last_grant_q;
    pop_tag      = tag_q[rd_ptr_q];
  end

  // Tag FIFO storage, pointers, count and arbitration state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pend_cnt_q   <= '0;
      last_grant_q <= 1'b1;
    end else begin
      if (push) tag_q[wr_ptr_q] <= gnt;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pend_cnt_q   <= pend_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Steer returning read data to the tagged master and latch spurious responses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      m0_rvalid_q <= pop && !pop_tag;
      m1_rvalid_q <= pop && pop_tag;
      if (pop && !pop_tag) m0_rdata_q <= s_readdata;
      if (pop && pop_tag)  m1_rdata_q <= s_readdata;
      if (spurious)        err_q      <= 1'b1;
    end
  end

  assign m0_readdata      = m0_rdata_q;
  assign m1_readdata      = m1_rdata_q;
  assign m0_readdatavalid = m0_rvalid_q;
  assign m1_readdatavalid = m1_rvalid_q;
  assign err_spurious     = err_q;

endmodule
